// File: rtl/sram_responder.sv
// sram_responder: shared-array memory responder for the inst/data SRAM ports, with 1-cycle reads, byte-strobe writes and out-of-range capture.
module sram_responder #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64,
  parameter int WEN_WD = 8,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = ADDR_WD'(64'h8000_0000),
  parameter int DEPTH_LOG2 = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_sram_en,
  input  logic [ADDR_WD-1:0] inst_sram_addr,
  output logic [DATA_WD-1:0] inst_sram_rdata,
  input  logic               data_sram_en,
  input  logic [WEN_WD-1:0]  data_sram_wen,
  input  logic [ADDR_WD-1:0] data_sram_addr,
  input  logic [DATA_WD-1:0] data_sram_wdata,
  output logic [DATA_WD-1:0] data_sram_rdata,
  output logic               acc_err,
  output logic [ADDR_WD-1:0] err_addr,
  output logic [31:0]        wr_cnt
);
  localparam int OFF_W = $clog2(WEN_WD);
  localparam int SPAN_W = DEPTH_LOG2 + OFF_W;
  logic [DATA_WD-1:0] mem [2**DEPTH_LOG2];
  logic [ADDR_WD-1:0] inst_off, data_off;
  logic [DEPTH_LOG2-1:0] inst_idx, data_idx;
  logic inst_in, data_in, inst_rd, data_rd, data_wr, inst_oor, data_oor;
  logic [DATA_WD-1:0] inst_rdata_d, inst_rdata_q, data_rdata_d, data_rdata_q;
  logic acc_err_d, acc_err_q;
  logic [ADDR_WD-1:0] err_addr_d, err_addr_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;
  always_comb begin
    inst_off = inst_sram_addr - BASE_ADDR;
    data_off = data_sram_addr - BASE_ADDR;
    inst_in = inst_sram_addr >= BASE_ADDR && (inst_off >> SPAN_W) == '0;
    data_in = data_sram_addr >= BASE_ADDR && (data_off >> SPAN_W) == '0;
    inst_idx = inst_off[SPAN_W-1:OFF_W];
    data_idx = data_off[SPAN_W-1:OFF_W];
    inst_rd = !reset && inst_sram_en;
    data_rd = !reset && data_sram_en && data_sram_wen == '0;
    data_wr = !reset && data_sram_en && data_sram_wen != '0 && data_in;
    inst_oor = !reset && inst_sram_en && !inst_in;
    data_oor = !reset && data_sram_en && !data_in;
    // array reads happen before the edge, so a same-cycle write is seen as read-first
    inst_rdata_d = inst_rd ? (inst_in ? mem[inst_idx] : '0) : inst_rdata_q;
    data_rdata_d = data_rd ? (data_in ? mem[data_idx] : '0) : data_rdata_q;
    acc_err_d = acc_err_q | inst_oor | data_oor;
    err_addr_d = acc_err_q ? err_addr_q : data_oor ? data_sram_addr : inst_oor ? inst_sram_addr : err_addr_q;
    wr_cnt_d = data_wr && !(&wr_cnt_q) ? wr_cnt_q + 32'd1 : wr_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      acc_err_q <= 1'b0;
      err_addr_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      acc_err_q <= acc_err_d;
      err_addr_q <= err_addr_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (data_wr)
      for (int i = 0; i < WEN_WD; i++)
        if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign acc_err = acc_err_q;
  assign err_addr = err_addr_q;
  assign wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder against a byte-level memory model.
module tb_sram_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] LIMIT = 64'h8008_0000;
  logic clk = 1'b0;
  logic reset;
  logic inst_sram_en;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_rdata;
  logic data_sram_en;
  logic [7:0] data_sram_wen;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;
  logic acc_err;
  logic [63:0] err_addr;
  logic [31:0] wr_cnt;
  int checks = 0;
  int failures = 0;
  logic [63:0] mdl [int unsigned];
  logic [63:0] q_i [$];
  logic [63:0] q_d [$];
  logic [63:0] last_i, last_d, e_eaddr;
  logic e_err;
  logic [31:0] e_cnt;

  sram_responder dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .acc_err(acc_err), .err_addr(err_addr), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return a >= BASE && a < LIMIT;
  endfunction

  function automatic int unsigned widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic idle();
    inst_sram_en = 0; inst_sram_addr = '0;
    data_sram_en = 0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
  endtask

  task automatic step();
    bit ri, rd;
    logic [63:0] w;
    ri = 0; rd = 0;
    if (!reset) begin
      if (inst_sram_en) begin
        ri = 1;
        q_i.push_back(in_rng(inst_sram_addr) ? mdl[widx(inst_sram_addr)] : 64'h0);
      end
      if (data_sram_en && data_sram_wen == 0) begin
        rd = 1;
        q_d.push_back(in_rng(data_sram_addr) ? mdl[widx(data_sram_addr)] : 64'h0);
      end
      if (!e_err && data_sram_en && !in_rng(data_sram_addr)) begin e_err = 1; e_eaddr = data_sram_addr; end
      if (!e_err && inst_sram_en && !in_rng(inst_sram_addr)) begin e_err = 1; e_eaddr = inst_sram_addr; end
      if (data_sram_en && data_sram_wen != 0 && in_rng(data_sram_addr)) begin
        w = mdl.exists(widx(data_sram_addr)) ? mdl[widx(data_sram_addr)] : 64'h0;
        for (int b = 0; b < 8; b++) if (data_sram_wen[b]) w[8*b +: 8] = data_sram_wdata[8*b +: 8];
        mdl[widx(data_sram_addr)] = w;
        if (e_cnt != 32'hFFFF_FFFF) e_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      last_i = '0; last_d = '0; e_err = 0; e_eaddr = '0; e_cnt = '0;
    end else begin
      if (ri) last_i = q_i.pop_front();
      if (rd) last_d = q_d.pop_front();
    end
    chk("inst_rdata", inst_sram_rdata, last_i);
    chk("data_rdata", data_sram_rdata, last_d);
    chk("acc_err", {63'h0, acc_err}, {63'h0, e_err});
    chk("err_addr", err_addr, e_eaddr);
    chk("wr_cnt", {32'h0, wr_cnt}, {32'h0, e_cnt});
    idle();
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    data_sram_en = 1; data_sram_wen = s; data_sram_addr = a; data_sram_wdata = d;
    step();
  endtask

  task automatic rd_d(input logic [63:0] a);
    data_sram_en = 1; data_sram_addr = a;
    step();
  endtask

  task automatic rd_i(input logic [63:0] a);
    inst_sram_en = 1; inst_sram_addr = a;
    step();
  endtask

  initial begin
    last_i = '0; last_d = '0; e_err = 0; e_eaddr = '0; e_cnt = '0;
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    wr(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
    rd_d(64'h8000_0010);
    chk("full_wr_rd", data_sram_rdata, 64'h1122_3344_5566_7788);
    chk("cnt_1", {32'h0, wr_cnt}, 64'd1);
    wr(64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    rd_d(64'h8000_0010);
    chk("partial_wr", data_sram_rdata, 64'h1122_3344_BBBB_BBBB);
    chk("cnt_2", {32'h0, wr_cnt}, 64'd2);
    rd_d(64'h8000_0013);
    chk("low_bits_ignored", data_sram_rdata, 64'h1122_3344_BBBB_BBBB);
    inst_sram_en = 1; inst_sram_addr = 64'h8000_0010;
    data_sram_en = 1; data_sram_wen = 8'hFF; data_sram_addr = 64'h8000_0010; data_sram_wdata = '0;
    step();
    chk("read_first", inst_sram_rdata, 64'h1122_3344_BBBB_BBBB);
    rd_i(64'h8000_0010);
    chk("after_write", inst_sram_rdata, 64'h0);
    for (int k = 0; k < 8; k++) wr(BASE + 64'(k) * 8 + 64'h100, 8'(1 << k) | 8'h81, {$urandom, $urandom});
    wr(BASE, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    wr(LIMIT - 8, 8'hFF, 64'hCAFE_0000_1234_5678);
    for (int k = 0; k < 8; k++) begin
      inst_sram_en = 1; inst_sram_addr = BASE + 64'(k) * 8 + 64'h100;
      data_sram_en = 1; data_sram_addr = BASE + 64'(7 - k) * 8 + 64'h100;
      step();
    end
    rd_d(LIMIT - 8);
    chk("last_word", data_sram_rdata, 64'hCAFE_0000_1234_5678);
    chk("no_err_yet", {63'h0, acc_err}, 64'h0);
    rd_d(64'h7FFF_FFF8);
    chk("oor_rd_zero", data_sram_rdata, 64'h0);
    chk("err_addr_1", err_addr, 64'h7FFF_FFF8);
    rd_i(64'h9000_0000);
    chk("oor_inst_zero", inst_sram_rdata, 64'h0);
    chk("err_addr_kept", err_addr, 64'h7FFF_FFF8);
    wr(LIMIT, 8'hFF, 64'h5555_5555_5555_5555);
    rd_d(BASE);
    chk("oor_wr_dropped", data_sram_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    rd_i(LIMIT - 8);
    for (int k = 0; k < 5; k++) step();
    chk("inst_hold", inst_sram_rdata, 64'hCAFE_0000_1234_5678);
    chk("data_hold", data_sram_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    reset = 1;
    data_sram_en = 1; data_sram_wen = 8'hFF; data_sram_addr = BASE; data_sram_wdata = 64'h0;
    step();
    reset = 0;
    chk("rst_err", {63'h0, acc_err}, 64'h0);
    chk("rst_cnt", {32'h0, wr_cnt}, 64'h0);
    rd_d(BASE);
    chk("survives_reset", data_sram_rdata, 64'hDEAD_BEEF_0BAD_F00D);
    inst_sram_en = 1; inst_sram_addr = 64'h1000;
    data_sram_en = 1; data_sram_addr = 64'h2000;
    step();
    chk("both_oor_data_wins", err_addr, 64'h2000);
    force dut.wr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_cnt_q;
    e_cnt = 32'hFFFF_FFFE;
    chk("cnt_preload", {32'h0, wr_cnt}, 64'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) wr(BASE + 64'h200, 8'h01, 64'(k));
    chk("cnt_sat", {32'h0, wr_cnt}, 64'hFFFF_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
